// File: rtl/multi_channel_sampler.sv
// Gated, decimating capture engine: snapshots NB_CHANNELS streams on each decimated tick
// and serialises them channel-interleaved into a capture memory, one word per cycle.
module multi_channel_sampler #(
  parameter int NB_CHANNELS      = 2,
  parameter int DATA_SIZE        = 16,
  parameter int ADDR_SIZE        = 13,
  parameter int IAGC_STATUS_SIZE = 4,
  parameter int DECIMATOR_SIZE   = 4,
  parameter int ST_SAMPLE        = 2,
  parameter int CH_SIZE          = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1
) (
  input  logic                             i_clock,
  input  logic                             i_reset_n,
  input  logic [IAGC_STATUS_SIZE-1:0]      i_iagc_status,
  input  logic [NB_CHANNELS*DATA_SIZE-1:0] i_data,
  input  logic                             i_gate,
  input  logic [ADDR_SIZE-1:0]             i_memory_size,
  input  logic [DECIMATOR_SIZE-1:0]        i_decimator,
  input  logic [1:0]                       i_mode,
  output logic [DATA_SIZE-1:0]             o_data,
  output logic [ADDR_SIZE-1:0]             o_addr,
  output logic                             o_wen,
  output logic [CH_SIZE-1:0]               o_channel,
  output logic                             o_end,
  output logic                             o_overrun
);

  localparam logic [CH_SIZE-1:0] LAST_CH    = CH_SIZE'(NB_CHANNELS - 1);
  localparam int                 FRAME_BITS = DATA_SIZE - CH_SIZE;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CAPTURE, S_WRITE, S_DONE} state_e;
  typedef enum logic [1:0] {SRC_LIVE, SRC_RAMP, SRC_ID, SRC_LIVE_ALT} src_e;

  state_e                    state_q;
  src_e                      mode_q;
  logic [ADDR_SIZE-1:0]      size_q, addr_q, waddr_q;
  logic [DECIMATOR_SIZE-1:0] dec_q, dec_cnt_q, dec_cnt_d;
  logic [CH_SIZE-1:0]        ch_q, chan_q;
  logic [DATA_SIZE-1:0]      frame_q, data_q;
  logic                      gate_q, overrun_q, wen_q, end_q;
  logic [DATA_SIZE-1:0]      snap_q [NB_CHANNELS];
  logic [DATA_SIZE-1:0]      snap_d [NB_CHANNELS];
  logic                      sampling, running, tick, last_word, last_ch;

  // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
  always_comb begin
    sampling  = (i_iagc_status == IAGC_STATUS_SIZE'(ST_SAMPLE));
    running   = (state_q == S_CAPTURE) || (state_q == S_WRITE);
    tick      = running && i_gate && (dec_cnt_q == dec_q);
    last_word = (addr_q == size_q - ADDR_SIZE'(1));
    last_ch   = (ch_q == LAST_CH);
    dec_cnt_d = dec_cnt_q;
    if (running && i_gate) dec_cnt_d = tick ? '0 : dec_cnt_q + DECIMATOR_SIZE'(1);
    for (int k = 0; k < NB_CHANNELS; k++) begin
      case (mode_q)
        SRC_RAMP: snap_d[k] = frame_q + DATA_SIZE'(k);
        SRC_ID:   snap_d[k] = {CH_SIZE'(k), frame_q[FRAME_BITS-1:0]};
        default:  snap_d[k] = i_data[k*DATA_SIZE +: DATA_SIZE];
      endcase
    end
  end

  // The last-channel write cycle doubles as a capture slot, so a tick period of
  // NB_CHANNELS cycles streams without gaps.
  // NOTE: the snapshot is pure datapath storage and is left out of reset; nothing reads it before a tick fills it.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      mode_q    <= SRC_LIVE;
      size_q    <= '0;
      dec_q     <= '0;
      addr_q    <= '0;
      dec_cnt_q <= '0;
      ch_q      <= '0;
      frame_q   <= '0;
      gate_q    <= 1'b0;
      overrun_q <= 1'b0;
      wen_q     <= 1'b0;
      end_q     <= 1'b0;
      data_q    <= '0;
      waddr_q   <= '0;
      chan_q    <= '0;
    end else begin
      gate_q <= i_gate;
      wen_q  <= 1'b0;
      if (!sampling) begin
        state_q   <= S_IDLE;
        end_q     <= 1'b0;
        overrun_q <= 1'b0;
        data_q    <= '0;
        waddr_q   <= '0;
        chan_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            size_q    <= i_memory_size;
            dec_q     <= i_decimator;
            mode_q    <= src_e'(i_mode);
            addr_q    <= '0;
            dec_cnt_q <= '0;
            ch_q      <= '0;
            frame_q   <= '0;
            overrun_q <= 1'b0;
            state_q   <= S_ARMED;
          end
          S_ARMED: if (i_gate && !gate_q) state_q <= S_CAPTURE;
          S_CAPTURE: begin
            dec_cnt_q <= dec_cnt_d;
            if (tick) begin
              snap_q  <= snap_d;
              frame_q <= frame_q + DATA_SIZE'(1);
              ch_q    <= '0;
              state_q <= S_WRITE;
            end
          end
          S_WRITE: begin
            dec_cnt_q <= dec_cnt_d;
            wen_q     <= 1'b1;
            data_q    <= snap_q[ch_q];
            waddr_q   <= addr_q;
            chan_q    <= ch_q;
            addr_q    <= addr_q + ADDR_SIZE'(1);
            if (tick && !last_ch) overrun_q <= 1'b1;
            if (last_word) begin
              state_q <= S_DONE;
            end else if (!last_ch) begin
              ch_q <= ch_q + CH_SIZE'(1);
            end else if (tick) begin
              snap_q  <= snap_d;
              frame_q <= frame_q + DATA_SIZE'(1);
              ch_q    <= '0;
            end else begin
              state_q <= S_CAPTURE;
            end
          end
          S_DONE:  end_q   <= 1'b1;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_data    = data_q;
  assign o_addr    = waddr_q;
  assign o_wen     = wen_q;
  assign o_channel = chan_q;
  assign o_end     = end_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_multi_channel_sampler.sv
// Bench for multi_channel_sampler: a 2-channel and a 4-channel instance share control inputs;
// expected writes come from a tick-schedule model built from recorded gate and data history.
module tb_multi_channel_sampler;
  localparam int AW = 13;
  localparam int ST = 2;

  typedef struct {
    int          cyc;
    int          addr;
    int          ch;
    logic [15:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  status;
  logic        gate_man, gate_rnd, gate_rand, gate_w;
  logic [12:0] msize;
  logic [3:0]  dec;
  logic [1:0]  mode;
  logic [31:0] data2;
  logic [63:0] data4;

  logic [15:0] o_data2, o_data4;
  logic [12:0] o_addr2, o_addr4;
  logic        o_wen2, o_wen4, o_end2, o_end4, o_ovr2, o_ovr4;
  logic [0:0]  o_ch2;
  logic [1:0]  o_ch4;

  int    tests = 0, fails = 0, cyc = 0, nprint = 0;
  int    end2, end4;
  int    run_e, run_size, run_d, run_mode;
  word_t obs2[$], obs4[$], exp_q[$];
  bit    exp_ovr;
  bit          hist_gate[int];
  logic [31:0] hist_d2[int];
  logic [63:0] hist_d4[int];

  assign gate_w = gate_rand ? gate_rnd : gate_man;

  multi_channel_sampler #(.NB_CHANNELS(2)) dut2 (
    .i_clock(clk), .i_reset_n(rst_n), .i_iagc_status(status), .i_data(data2), .i_gate(gate_w),
    .i_memory_size(msize), .i_decimator(dec), .i_mode(mode), .o_data(o_data2), .o_addr(o_addr2),
    .o_wen(o_wen2), .o_channel(o_ch2), .o_end(o_end2), .o_overrun(o_ovr2));

  multi_channel_sampler #(.NB_CHANNELS(4)) dut4 (
    .i_clock(clk), .i_reset_n(rst_n), .i_iagc_status(status), .i_data(data4), .i_gate(gate_w),
    .i_memory_size(msize), .i_decimator(dec), .i_mode(mode), .o_data(o_data4), .o_addr(o_addr4),
    .o_wen(o_wen4), .o_channel(o_ch4), .o_end(o_end4), .o_overrun(o_ovr4));

  always #5 clk = ~clk;

  // Inputs only move on negedges, so the posedge sees exactly what the DUT samples.
  always @(posedge clk) begin
    cyc = cyc + 1;
    hist_gate[cyc] = gate_w;
    hist_d2[cyc]   = data2;
    hist_d4[cyc]   = data4;
  end

  initial begin
    data2 = '0; data4 = '0; gate_rnd = 1'b0;
    forever begin
      @(negedge clk);
      data2    = $urandom;
      data4    = {$urandom, $urandom};
      gate_rnd = ($urandom_range(3) != 0);
    end
  end

  always @(negedge clk) begin
    if (o_wen2) obs2.push_back('{cyc, int'(o_addr2), int'(o_ch2), o_data2});
    if (o_wen4) obs4.push_back('{cyc, int'(o_addr4), int'(o_ch4), o_data4});
    if (o_end2 && end2 < 0) end2 = cyc;
    if (o_end4 && end4 < 0) end4 = cyc;
  end

  // Reference: every (D+1)-th gate-high edge after arming is a tick; a tick is taken when no
  // frame is still being written, otherwise it is dropped and flags an overrun.
  task automatic build_model(input int inst);
    int nb, words, p, cnt, f, produced, last_t, last_w, chsz;
    logic [63:0] row;
    logic [15:0] d;
    nb = (inst == 0) ? 2 : 4;
    chsz = (inst == 0) ? 1 : 2;
    words = (run_size == 0) ? (1 << AW) : run_size;
    p = run_d + 1;
    exp_q.delete();
    exp_ovr = 1'b0;
    cnt = 0; f = 0; produced = 0; last_t = -1000; last_w = 0;
    for (int t = run_e + 1; t <= cyc; t++) begin
      if (produced >= words && t > last_t + last_w) break;
      if (hist_gate[t]) begin
        cnt++;
        if (cnt == p) begin
          cnt = 0;
          if (produced < words && t >= last_t + nb) begin
            last_w = 0;
            row = (inst == 0) ? {32'h0, hist_d2[t]} : hist_d4[t];
            for (int k = 0; k < nb; k++) begin
              if (produced < words) begin
                case (run_mode)
                  1:       d = 16'(f + k);
                  2:       d = 16'((k << (16 - chsz)) | (f & ((1 << (16 - chsz)) - 1)));
                  default: d = row[k*16 +: 16];
                endcase
                exp_q.push_back('{t + 1 + k, produced % (1 << AW), k, d});
                produced++;
                last_w++;
              end
            end
            last_t = t;
            f++;
          end else if (t < last_t + nb && t <= last_t + last_w) begin
            exp_ovr = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_run(input int inst, input string tag);
    word_t o[$];
    int    e, exp_end;
    logic  ovr;
    if (inst == 0) begin o = obs2; e = end2; ovr = o_ovr2; end
    else           begin o = obs4; e = end4; ovr = o_ovr4; end
    build_model(inst);
    exp_end = (exp_q.size() > 0) ? exp_q[exp_q.size()-1].cyc + 1 : -1;
    tests++;
    if (o.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s write count: got %0d, expected %0d", tag, o.size(), exp_q.size());
    end
    for (int i = 0; i < o.size() && i < exp_q.size(); i++) begin
      tests++;
      if (o[i].cyc != exp_q[i].cyc || o[i].addr != exp_q[i].addr || o[i].ch != exp_q[i].ch ||
          o[i].data !== exp_q[i].data) begin
        fails++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL %s word %0d: got cyc=%0d addr=%0d ch=%0d data=%h, expected cyc=%0d addr=%0d ch=%0d data=%h",
                   tag, i, o[i].cyc, o[i].addr, o[i].ch, o[i].data,
                   exp_q[i].cyc, exp_q[i].addr, exp_q[i].ch, exp_q[i].data);
        end
      end
    end
    tests++;
    if (e != exp_end) begin
      fails++;
      $display("FAIL %s end cycle: got %0d, expected %0d", tag, e, exp_end);
    end
    tests++;
    if (ovr !== exp_ovr) begin
      fails++;
      $display("FAIL %s overrun: got %b, expected %b", tag, ovr, exp_ovr);
    end
  endtask

  task automatic arm(input int size, input int d, input int md);
    obs2.delete(); obs4.delete();
    end2 = -1; end4 = -1;
    run_size = size; run_d = d; run_mode = md;
    msize = 13'(size); dec = 4'(d); mode = 2'(md);
    status = 4'(ST);
  endtask

  task automatic raise_gate();
    gate_man = 1'b1;
    run_e = cyc + 1;
  endtask

  task automatic wait_end(input int bound, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (end2 >= 0 && end4 >= 0) begin done = 1'b1; break; end
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s timeout: end2=%0d end4=%0d after %0d cycles", tag, end2, end4, bound);
    end
    repeat (3) @(negedge clk);
    gate_rand = 1'b0;
    gate_man  = 1'b0;
  endtask

  task automatic end_run();
    status = 4'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_run(input int size, input int d, input int md, input bit rnd, input int bound,
                        input string tag);
    arm(size, d, md);
    @(negedge clk);
    raise_gate();
    if (rnd) begin
      @(negedge clk);
      gate_rand = 1'b1;
    end
    wait_end(bound, tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; status = 4'd0; gate_man = 1'b0; gate_rand = 1'b0;
    msize = '0; dec = '0; mode = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({o_data2, o_addr2, o_wen2, o_ch2, o_end2, o_ovr2} !== '0) begin
      fails++;
      $display("FAIL reset dut2 outputs: got %h, expected 0", {o_data2, o_addr2, o_wen2, o_ch2, o_end2, o_ovr2});
    end
    tests++;
    if ({o_data4, o_addr4, o_wen4, o_ch4, o_end4, o_ovr4} !== '0) begin
      fails++;
      $display("FAIL reset dut4 outputs: got %h, expected 0", {o_data4, o_addr4, o_wen4, o_ch4, o_end4, o_ovr4});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ramp_basic();
    logic [15:0] ramp_ref [8] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd4};
    do_run(8, 3, 1, 1'b0, 300, "ramp");
    tests++;
    if (obs2.size() != 8) begin
      fails++;
      $display("FAIL ramp count: got %0d, expected 8", obs2.size());
    end
    for (int i = 0; i < obs2.size() && i < 8; i++) begin
      tests++;
      if (obs2[i].addr != i || obs2[i].data !== ramp_ref[i] ||
          obs2[i].cyc - obs2[0].cyc != (i / 2) * 4 + (i % 2)) begin
        fails++;
        $display("FAIL ramp word %0d: got addr=%0d data=%h dcyc=%0d, expected addr=%0d data=%h dcyc=%0d",
                 i, obs2[i].addr, obs2[i].data, obs2[i].cyc - obs2[0].cyc, i, ramp_ref[i], (i / 2) * 4 + (i % 2));
      end
    end
    tests++;
    if (o_end2 !== 1'b1 || o_wen2 !== 1'b0) begin
      fails++;
      $display("FAIL ramp done: got end=%b wen=%b, expected end=1 wen=0", o_end2, o_wen2);
    end
    compare_run(0, "ramp2");
    compare_run(1, "ramp4");
    end_run();
  endtask

  task automatic test_gate_edge();
    gate_man = 1'b1;
    @(negedge clk);
    arm(6, 5, 2);
    repeat (50) @(negedge clk);
    tests++;
    if (obs2.size() != 0 || obs4.size() != 0) begin
      fails++;
      $display("FAIL gate_held writes: got %0d/%0d, expected 0/0", obs2.size(), obs4.size());
    end
    gate_man = 1'b0;
    @(negedge clk);
    raise_gate();
    wait_end(300, "gate_edge");
    tests++;
    if (obs2.size() == 0 || obs2[0].cyc != run_e + 5 + 2) begin
      fails++;
      $display("FAIL gate_edge first write: got cyc=%0d, expected %0d",
               (obs2.size() > 0) ? obs2[0].cyc : -1, run_e + 7);
    end
    compare_run(0, "gate_edge2");
    compare_run(1, "gate_edge4");
    end_run();
  endtask

  task automatic test_random_modes();
    for (int it = 0; it < 6; it++) begin
      do_run($urandom_range(24, 1), $urandom_range(7, 3), $urandom_range(3, 0), 1'b1, 2000, "random");
      compare_run(0, $sformatf("random%0d_nb2", it));
      compare_run(1, $sformatf("random%0d_nb4", it));
      end_run();
    end
  endtask

  task automatic test_overrun();
    do_run(16, 0, 0, 1'b0, 500, "overrun");
    tests++;
    if (o_ovr4 !== 1'b1) begin
      fails++;
      $display("FAIL overrun flag nb4: got %b, expected 1", o_ovr4);
    end
    compare_run(0, "overrun2");
    compare_run(1, "overrun4");
    end_run();
  endtask

  task automatic test_truncated_id();
    do_run(5, 3, 2, 1'b0, 300, "trunc_id");
    tests++;
    if (obs2.size() != 5 || obs2[4].addr != 4 || obs2[4].ch != 0 || obs2[4].data !== 16'h0002) begin
      fails++;
      $display("FAIL trunc_id last word: got n=%0d addr=%0d ch=%0d data=%h, expected n=5 addr=4 ch=0 data=0002",
               obs2.size(), (obs2.size() > 4) ? obs2[4].addr : -1, (obs2.size() > 4) ? obs2[4].ch : -1,
               (obs2.size() > 4) ? obs2[4].data : 16'hxxxx);
    end
    compare_run(0, "trunc_id2");
    compare_run(1, "trunc_id4");
    end_run();
  endtask

  task automatic test_abort();
    bit seen = 1'b0;
    arm(8, 3, 1);
    @(negedge clk);
    raise_gate();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_wen2 && o_addr2 == 13'd2) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL abort third write: got none within 200 cycles, expected addr 2");
    end
    status = 4'd0;
    @(negedge clk);
    tests++;
    if (o_wen2 !== 1'b0) begin
      fails++;
      $display("FAIL abort wen: got %b, expected 0", o_wen2);
    end
    repeat (20) @(negedge clk);
    tests++;
    if (obs2.size() != 3 || end2 != -1) begin
      fails++;
      $display("FAIL abort aftermath: got writes=%0d end_cycle=%0d, expected writes=3 end_cycle=-1", obs2.size(), end2);
    end
    gate_man = 1'b0;
    @(negedge clk);
    do_run(4, 3, 1, 1'b0, 300, "rerun");
    tests++;
    if (obs2.size() == 0 || obs2[0].addr != 0) begin
      fails++;
      $display("FAIL rerun first addr: got %0d, expected 0", (obs2.size() > 0) ? obs2[0].addr : -1);
    end
    compare_run(0, "rerun2");
    end_run();
  endtask

  task automatic test_size_zero();
    do_run(0, 1, 0, 1'b0, 20000, "size0");
    tests++;
    if (obs2.size() != 8192 || obs2[obs2.size()-1].addr != 8191) begin
      fails++;
      $display("FAIL size0 extent: got n=%0d last_addr=%0d, expected n=8192 last_addr=8191",
               obs2.size(), (obs2.size() > 0) ? obs2[obs2.size()-1].addr : -1);
    end
    compare_run(0, "size0_nb2");
    compare_run(1, "size0_nb4");
    end_run();
  endtask

  task automatic test_reset_mid_write();
    bit seen = 1'b0;
    arm(16, 0, 0);
    @(negedge clk);
    raise_gate();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_wen2 && o_addr2 == 13'd2) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen || o_ovr2 !== 1'b1) begin
      fails++;
      $display("FAIL pre-reset overrun: got seen=%b ovr=%b, expected seen=1 ovr=1", seen, o_ovr2);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({o_data2, o_addr2, o_wen2, o_ch2, o_end2, o_ovr2} !== '0 ||
        {o_data4, o_addr4, o_wen4, o_ch4, o_end4, o_ovr4} !== '0) begin
      fails++;
      $display("FAIL reset_mid_write outputs: got %h / %h, expected 0 / 0",
               {o_data2, o_addr2, o_wen2, o_ch2, o_end2, o_ovr2}, {o_data4, o_addr4, o_wen4, o_ch4, o_end4, o_ovr4});
    end
    rst_n = 1'b1;
    status = 4'd0;
    gate_man = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    end2 = -1; end4 = -1;
    test_reset();
    test_ramp_basic();
    test_gate_edge();
    test_random_modes();
    test_overrun();
    test_truncated_id();
    test_abort();
    test_size_zero();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
